// File: rtl/uart_tx_responder_if.sv
// rtl/uart_tx_responder_if.sv - CPU data-memory bus bundle shared by the UART TX responder
interface uart_tx_responder_if;
  logic [31:0] address;
  logic [3:0]  width;
  logic        write_en;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (output address, width, write_en, data_in, input data_out);
  modport slave  (input address, width, write_en, data_in, output data_out);
endinterface

// File: rtl/uart_tx_responder.sv
// rtl/uart_tx_responder.sv - memory-mapped UART transmitter (TX FIFO + 8N1 serial engine)
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
  parameter int          FIFO_DEPTH    = 8,
  parameter logic [15:0] DIVISOR_RESET = 16'd4
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_tx_responder_if.slave bus,
  output logic               tx,
  output logic               irq
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic [15:0]   r_divisor;
  logic [2:0]    r_state;
  logic [15:0]   r_timer, r_bit_div;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx, r_irq;
  logic [31:0]   r_data_out;

  logic          w_sel, w_wr, w_rd;
  logic [3:0]    w_off;
  logic          w_push_req, w_push, w_pop, w_drop;
  logic          w_stat_wr, w_div_wr;
  logic          w_empty, w_full, w_bit_end, w_tx_bit;
  logic [15:0]   w_div_eff;
  logic [31:0]   w_status, w_rdata;
  logic          w_unused;

  assign w_unused   = &{1'b0, bus.data_in[31:16]};
  assign w_off      = bus.address[3:0];
  assign w_sel      = (bus.address[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = w_sel && bus.write_en && (bus.width != 4'd0);
  assign w_rd       = w_sel && !bus.write_en && (bus.width == 4'd4);
  assign w_push_req = w_wr && (w_off == 4'h0) &&
                      (bus.width == 4'd1 || bus.width == 4'd2 || bus.width == 4'd4);
  assign w_stat_wr  = w_wr && (w_off == 4'h4) && (bus.width == 4'd4);
  assign w_div_wr   = w_wr && (w_off == 4'h8) && (bus.width == 4'd4);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_div_eff  = (r_divisor == 16'd0) ? 16'd1 : r_divisor;
  assign w_bit_end  = (r_timer == r_bit_div - 16'd1);
  // STOP pops on its last cycle so the next START follows with no idle gap
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_push;

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_full;
    w_status[1]       = w_empty;
    w_status[2]       = (r_state != S_IDLE);
    w_status[3]       = r_overflow;
`ifdef UART_TX_PARITY_EN
    w_status[4]       = 1'b1;
`endif
    w_status[8 +: AW+1] = r_count;
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      if (w_off == 4'h4)      w_rdata = w_status;
      else if (w_off == 4'h8) w_rdata = {16'd0, r_divisor};
    end
  end

  always_comb begin
    w_tx_bit = 1'b1;
    case (r_state)
      S_START:  w_tx_bit = 1'b0;
      S_DATA:   w_tx_bit = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_bit = ^r_shift;
`endif
      default:  w_tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_divisor  <= DIVISOR_RESET;
      r_data_out <= '0;
      r_irq      <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)                           r_overflow <= 1'b1;
      else if (w_stat_wr && bus.data_in[3]) r_overflow <= 1'b0;
      if (w_div_wr) r_divisor <= bus.data_in[15:0];
      r_data_out <= w_rdata;
      r_irq      <= w_empty && (r_state == S_IDLE);
    end
  end

  // tx is registered from the state, so the line trails the FSM by one cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_div <= 16'd1;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_bit;
      if (r_state == S_IDLE || w_bit_end) begin
        r_timer   <= '0;
        r_bit_div <= w_div_eff;
      end else begin
        r_timer   <= r_timer + 16'd1;
      end
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_shift <= r_mem[r_rd_ptr];
          r_state <= S_START;
        end
        S_START: if (w_bit_end) begin
          r_bit_idx <= 3'd0;
          r_state   <= S_DATA;
        end
        S_DATA: if (w_bit_end) begin
          r_bit_idx <= r_bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (r_bit_idx == 3'd7) r_state <= S_PARITY;
`else
          if (r_bit_idx == 3'd7) r_state <= S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (w_bit_end) r_state <= S_STOP;
`endif
        S_STOP: if (w_bit_end) begin
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_state <= S_START;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign tx           = r_tx;
  assign irq          = r_irq;
endmodule

// File: tb/tb_uart_tx_responder.sv
// tb/tb_uart_tx_responder.sv - self-checking bench for uart_tx_responder (honours UART_TX_PARITY_EN)
module tb_uart_tx_responder;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int          NBITS = 10 + PAR;
  localparam logic [31:0] ST_P  = (PAR != 0) ? 32'h10 : 32'h0;
  localparam int          LOGN  = 4096;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic tx, irq;
  uart_tx_responder_if bus();

  uart_tx_responder dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  width;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vt[16];

  logic [7:0]  s_byte[16];
  int          s_edge[16];
  int          s_n, s_div, rd_edge;
  logic [31:0] rd_exp;
  logic        tx_log[LOGN];
  logic        irq_log[LOGN];
  logic        exp_tx[LOGN];
  logic [31:0] rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.address  = '0;
    bus.width    = 4'd0;
    bus.write_en = 1'b0;
    bus.data_in  = '0;
  endtask

  task automatic bus_op(input logic we, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output logic [31:0] q);
    @(negedge clock);
    bus.address  = a;
    bus.width    = w;
    bus.write_en = we;
    bus.data_in  = d;
    @(posedge clock);
    #1;
    q = bus.data_out;
    bus_idle();
  endtask

  task automatic set_div(input int d);
    logic [31:0] q;
    bus_op(1'b1, 32'h1008, 4'd4, d, q);
  endtask

  // Expected line: a byte written on edge w starts at max(w+2, end of previous frame).
  task automatic run_stream(input string name);
    int eff, len, prev_end, s, j, ncyc, wi, bad, first_bad;
    logic [7:0]  b;
    logic [31:0] d;
    logic [31:0] q;
    eff = (s_div == 0) ? 1 : s_div;
    len = NBITS * eff;
    for (int c = 0; c < LOGN; c++) exp_tx[c] = 1'b1;
    prev_end = 0;
    for (int i = 0; i < s_n; i++) begin
      s = (s_edge[i] + 2 > prev_end) ? s_edge[i] + 2 : prev_end;
      b = s_byte[i];
      for (int k = 0; k < len; k++) begin
        j = k / eff;
        if (j == 0)                  exp_tx[s+k] = 1'b0;
        else if (j <= 8)             exp_tx[s+k] = b[j-1];
        else if (PAR != 0 && j == 9) exp_tx[s+k] = ^b;
        else                         exp_tx[s+k] = 1'b1;
      end
      prev_end = s + len;
    end
    ncyc = prev_end + 3;
    set_div(s_div);
    wi = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      if (wi < s_n && s_edge[wi] == c) begin
        d = $urandom;
        d[7:0] = s_byte[wi];
        bus.address = 32'h1000; bus.write_en = 1'b1; bus.data_in = d;
        bus.width = 4'(1 << $urandom_range(0, 2));
        wi++;
      end else if (c == rd_edge) begin
        bus.address = 32'h1004; bus.write_en = 1'b0; bus.width = 4'd4; bus.data_in = '0;
      end else begin
        bus_idle();
      end
      @(posedge clock);
      #1;
      tx_log[c]  = tx;
      irq_log[c] = irq;
      if (c == rd_edge) check({name, "_status"}, bus.data_out, rd_exp);
    end
    bus_idle();
    bad = 0;
    first_bad = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (tx_log[c] !== exp_tx[c]) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_tx: %0d cycles differ, first at %0d (got %b expected %b)",
               name, bad, first_bad, tx_log[first_bad], exp_tx[first_bad]);
    end
    check({name, "_irq_end"}, irq_log[ncyc-1], 1);
    rd_edge = -1;
    bus_op(1'b0, 32'h1004, 4'd4, 0, q);
    check({name, "_idle_status"}, q, 32'h2 | ST_P);
  endtask

  initial begin
    bus_idle();
    rd_edge = -1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_tx", tx, 1);
    check("reset_irq", irq, 1);
    check("reset_dout", bus.data_out, 0);
    @(negedge clock) reset_n = 1'b1;

    vt[0]  = '{0, 32'h1004, 4'd4, 32'h0,         32'h2 | ST_P, "status_idle"};
    vt[1]  = '{1, 32'h1008, 4'd4, 32'h7,         32'h0,        "div_wr_dout"};
    vt[2]  = '{0, 32'h1008, 4'd4, 32'h0,         32'h7,        "div_rd"};
    vt[3]  = '{1, 32'h1008, 4'd2, 32'h99,        32'h0,        "div_w2_dout"};
    vt[4]  = '{0, 32'h1008, 4'd4, 32'h0,         32'h7,        "div_w2_ignored"};
    vt[5]  = '{0, 32'h2004, 4'd4, 32'h0,         32'h0,        "unselected"};
    vt[6]  = '{0, 32'h1004, 4'd1, 32'h0,         32'h0,        "rd_width1"};
    vt[7]  = '{0, 32'h100C, 4'd4, 32'h0,         32'h0,        "reserved_rd"};
    vt[8]  = '{0, 32'h1000, 4'd4, 32'h0,         32'h0,        "txdata_rd"};
    vt[9]  = '{1, 32'h100C, 4'd4, 32'hFFFF,      32'h0,        "reserved_wr"};
    vt[10] = '{0, 32'h1008, 4'd4, 32'h0,         32'h7,        "reserved_wr_ignored"};
    vt[11] = '{1, 32'h1008, 4'd4, 32'hABCD_1234, 32'h0,        "div_wr_full"};
    vt[12] = '{0, 32'h1008, 4'd4, 32'h0,         32'h1234,     "div_low16"};
    vt[13] = '{1, 32'h1004, 4'd4, 32'hFFFF_FFF7, 32'h0,        "status_wr"};
    vt[14] = '{0, 32'h1004, 4'd4, 32'h0,         32'h2 | ST_P, "status_wr_ignored"};
    vt[15] = '{0, 32'h1004, 4'd0, 32'h0,         32'h0,        "no_access"};
    for (int i = 0; i < 16; i++) begin
      bus_op(vt[i].we, vt[i].addr, vt[i].width, vt[i].data, rd);
      check(vt[i].name, rd, vt[i].exp);
    end

    // single byte 0x55, divisor 4
    s_div = 4; s_n = 1; s_byte[0] = 8'h55; s_edge[0] = 0;
    run_stream("single");
    check("single_irq_before", irq_log[0], 1);
    check("single_irq_fall", irq_log[1], 0);

    // back-to-back frames with a mid-transfer STATUS read
    s_div = 4; s_n = 2; s_byte[0] = 8'hA5; s_byte[1] = 8'h3C; s_edge[0] = 0; s_edge[1] = 1;
    rd_edge = 5; rd_exp = 32'h104 | ST_P;
    run_stream("b2b");

    // divisor 0 behaves as 1-cycle bits
    s_div = 0; s_n = 2; s_byte[0] = 8'h96; s_byte[1] = 8'h01; s_edge[0] = 0; s_edge[1] = 1;
    run_stream("div0");
    bus_op(1'b0, 32'h1008, 4'd4, 0, rd);
    check("div0_readback", rd, 0);

    s_div = 2; s_n = 1; s_byte[0] = 8'h07; s_edge[0] = 0;
    run_stream("par07");

    for (int r = 0; r < 4; r++) begin
      s_div = $urandom_range(0, 5);
      s_n   = $urandom_range(1, 8);
      for (int i = 0; i < s_n; i++) begin
        s_byte[i] = 8'($urandom);
        if (i == 0)                       s_edge[i] = 0;
        else if ($urandom_range(0, 1) == 0) s_edge[i] = s_edge[i-1] + 1;
        else s_edge[i] = s_edge[i-1] + $urandom_range(1, 2 * NBITS * ((s_div == 0) ? 1 : s_div));
      end
      run_stream($sformatf("rand%0d", r));
    end

    // overflow: one byte in the engine, eight in the FIFO, tenth dropped
    set_div(100);
    for (int i = 0; i < 10; i++) bus_op(1'b1, 32'h1000, 4'd1, 32'h40 + i, rd);
    bus_op(1'b0, 32'h1004, 4'd4, 0, rd);
    check("ovf_status", rd, 32'h80D | ST_P);
    bus_op(1'b1, 32'h1004, 4'd4, 32'h8, rd);
    bus_op(1'b0, 32'h1004, 4'd4, 0, rd);
    check("ovf_clear", rd, 32'h805 | ST_P);
    check("ovf_irq", irq, 0);

    // reset in the middle of a frame
    @(negedge clock) reset_n = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    set_div(4);
    bus_op(1'b1, 32'h1000, 4'd1, 32'h00, rd);
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_tx", tx, 0);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid_tx", tx, 1);
    check("reset_mid_irq", irq, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    bus_op(1'b0, 32'h1004, 4'd4, 0, rd);
    check("reset_mid_status", rd, 32'h2 | ST_P);
    check("reset_mid_irq_after", irq, 1);
    bus_op(1'b0, 32'h1008, 4'd4, 0, rd);
    check("reset_div", rd, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
